// File: rtl/cpu_sequencer.sv
// Four-state fetch/decode/execute sequencer: fetches into ir, gates decoder strobes to a single
// completing cycle, stalls on IO handshakes and computes the next pc from the branch select.
module cpu_sequencer #(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [16:0]         imem_data,
    input  logic                imem_ready,
    input  logic [1:0]          BS_in,
    input  logic                PS_in,
    input  logic                RW_in,
    input  logic                MW_in,
    input  logic                out_we_in,
    input  logic                in_en_in,
    input  logic                zero,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                in_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic                imem_req,
    output logic [16:0]         ir,
    output logic                RW,
    output logic                MW,
    output logic                out_we,
    output logic                in_en,
    output logic                retire,
    output logic [15:0]         retired_count
);

    localparam logic [1:0] FETCH  = 2'b00;
    localparam logic [1:0] DECODE = 2'b01;
    localparam logic [1:0] EXEC   = 2'b10;
    localparam logic [1:0] IOWAIT = 2'b11;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_next, pc_inc;
    logic [16:0]         ir_q;
    logic [15:0]         count_q;
    logic                io_block, complete, fire;

    always_comb begin
        io_block = (in_en_in && !in_valid) || (out_we_in && !out_ready);
        complete = ((state_q == EXEC) || (state_q == IOWAIT)) && !io_block;
        // Reset wins over a completing cycle: no strobe, no retire.
        fire     = complete && !reset;
    end

    always_comb begin
        pc_inc  = pc_q + PC_WIDTH'(1);
        pc_next = pc_inc;
        case (BS_in)
            2'b00:   pc_next = pc_inc;
            2'b01:   pc_next = zero ? branch_target : pc_inc;
            2'b10:   pc_next = jump_target;
            default: pc_next = (PS_in && zero) ? pc_inc : branch_target;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:        state_d = imem_ready ? DECODE : FETCH;
            DECODE:       state_d = EXEC;
            EXEC, IOWAIT: state_d = io_block ? IOWAIT : FETCH;
            default:      state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && imem_ready) begin
                ir_q <= imem_data;
            end
            if (complete) begin
                pc_q    <= pc_next;
                count_q <= count_q + 16'd1;
            end
        end
    end

    always_comb begin
        pc            = pc_q;
        ir            = ir_q;
        retired_count = count_q;
        imem_req      = (state_q == FETCH);
        retire        = fire;
        RW            = fire && RW_in;
        MW            = fire && MW_in;
        out_we        = fire && out_we_in;
        in_en         = fire && in_en_in;
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, ALU retire timing, branches, IO stalls, pc wrap and
// reset during an IO stall.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] imem_data;
    logic        imem_ready;
    logic [1:0]  BS_in;
    logic        PS_in, RW_in, MW_in, out_we_in, in_en_in, zero;
    logic [7:0]  branch_target, jump_target;
    logic        in_valid, out_ready;
    logic [7:0]  pc;
    logic        imem_req;
    logic [16:0] ir;
    logic        RW, MW, out_we, in_en, retire;
    logic [15:0] retired_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    cpu_sequencer #(.PC_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .imem_data(imem_data), .imem_ready(imem_ready),
        .BS_in(BS_in), .PS_in(PS_in), .RW_in(RW_in), .MW_in(MW_in), .out_we_in(out_we_in),
        .in_en_in(in_en_in), .zero(zero), .branch_target(branch_target),
        .jump_target(jump_target), .in_valid(in_valid), .out_ready(out_ready), .pc(pc),
        .imem_req(imem_req), .ir(ir), .RW(RW), .MW(MW), .out_we(out_we), .in_en(in_en),
        .retire(retire), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_decoder();
        BS_in = 2'b00; PS_in = 1'b0; RW_in = 1'b0; MW_in = 1'b0;
        out_we_in = 1'b0; in_en_in = 1'b0; zero = 1'b0;
        branch_target = 8'h00; jump_target = 8'h00;
    endtask

    // From FETCH, present word for one cycle and step through DECODE into EXEC.
    task automatic issue(input logic [16:0] word);
        imem_data = word; imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b0; imem_data = '0; in_valid = 1'b1; out_ready = 1'b1;
        clear_decoder();
        tick(); tick();
        #1;
        checks++;
        if (pc !== 8'h00 || ir !== 17'h0 || retired_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: got pc=%h ir=%h cnt=%h want 00/0/0", pc, ir, retired_count);
        end
        checks++;
        if ({RW, MW, out_we, in_en, retire} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000", {RW, MW, out_we, in_en, retire});
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_imem_req: got %b want 1", imem_req);
        end
    endtask

    task automatic test_add();
        clear_decoder();
        RW_in = 1'b1;
        imem_data = 17'h1_2345; imem_ready = 1'b1;
        #1;
        checks++;
        if (RW !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL add_fetch: got RW=%b req=%b want 0/1", RW, imem_req);
        end
        tick();
        imem_ready = 1'b0;
        #1;
        checks++;
        if (ir !== 17'h1_2345 || RW !== 1'b0 || imem_req !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL add_decode: got ir=%h RW=%b req=%b ret=%b want 12345/0/0/0",
                     ir, RW, imem_req, retire);
        end
        tick();
        #1;
        checks++;
        if (RW !== 1'b1 || retire !== 1'b1 || MW !== 1'b0 || pc !== 8'h00) begin
            errors++;
            $display("FAIL add_exec: got RW=%b ret=%b MW=%b pc=%h want 1/1/0/00",
                     RW, retire, MW, pc);
        end
        tick();
        exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h01 || retired_count !== exp_cnt || RW !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL add_done: got pc=%h cnt=%h RW=%b ret=%b want 01/%h/0/0",
                     pc, retired_count, RW, retire, exp_cnt);
        end
    endtask

    task automatic test_branch();
        clear_decoder();
        BS_in = 2'b01; branch_target = 8'h20; zero = 1'b0;
        issue(17'h0_4001);
        zero = 1'b1;  // only the completing cycle's flag matters
        #1;
        checks++;
        if (RW !== 1'b0 || retire !== 1'b1) begin
            errors++;
            $display("FAIL bz_taken_exec: got RW=%b ret=%b want 0/1", RW, retire);
        end
        tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h20) begin
            errors++;
            $display("FAIL bz_taken_pc: got %h want 20", pc);
        end
        zero = 1'b1;
        issue(17'h0_4002);
        zero = 1'b0;
        #1;
        checks++;
        if (RW !== 1'b0) begin
            errors++;
            $display("FAIL bz_not_taken_rw: got %b want 0", RW);
        end
        tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h21) begin
            errors++;
            $display("FAIL bz_not_taken_pc: got %h want 21", pc);
        end
    endtask

    task automatic test_bnz_jump();
        clear_decoder();
        BS_in = 2'b11; PS_in = 1'b1; branch_target = 8'h40; zero = 1'b0;
        issue(17'h0_6003); tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h40) begin
            errors++;
            $display("FAIL bnz_taken_pc: got %h want 40", pc);
        end
        zero = 1'b1;
        issue(17'h0_6004); tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h41) begin
            errors++;
            $display("FAIL bnz_not_taken_pc: got %h want 41", pc);
        end
        PS_in = 1'b0; branch_target = 8'h10; zero = 1'b1;
        issue(17'h0_6005); tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h10) begin
            errors++;
            $display("FAIL bra_pc: got %h want 10", pc);
        end
        BS_in = 2'b10; PS_in = 1'b0; jump_target = 8'h80; branch_target = 8'h33;
        issue(17'h0_5006); tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h80 || retired_count !== exp_cnt) begin
            errors++;
            $display("FAIL jmp_pc: got pc=%h cnt=%h want 80/%h", pc, retired_count, exp_cnt);
        end
    endtask

    task automatic test_io_wait();
        int stall_errs;
        clear_decoder();
        in_en_in = 1'b1; RW_in = 1'b1; in_valid = 1'b0;
        issue(17'h1_C007);
        #1;
        checks++;
        if ({RW, in_en, retire} !== 3'b000) begin
            errors++;
            $display("FAIL in_exec_blocked: got %b want 000", {RW, in_en, retire});
        end
        stall_errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            imem_data = 17'h1_FFFF; imem_ready = 1'b1;
            #1;
            if ({RW, MW, out_we, in_en, retire, imem_req} !== 6'b0 || ir !== 17'h1_C007 ||
                pc !== 8'h80) begin
                stall_errs++;
            end
        end
        imem_ready = 1'b0;
        checks++;
        if (stall_errs != 0) begin
            errors++;
            $display("FAIL in_iowait_hold: got %0d bad cycles want 0", stall_errs);
        end
        tick();
        in_valid = 1'b1;
        #1;
        checks++;
        if ({RW, in_en, retire, MW, out_we} !== 5'b11100) begin
            errors++;
            $display("FAIL in_complete: got %b want 11100", {RW, in_en, retire, MW, out_we});
        end
        tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h81 || in_en !== 1'b0 || imem_req !== 1'b1 || retired_count !== exp_cnt) begin
            errors++;
            $display("FAIL in_done: got pc=%h in_en=%b req=%b cnt=%h want 81/0/1/%h",
                     pc, in_en, imem_req, retired_count, exp_cnt);
        end
        clear_decoder();
        out_we_in = 1'b1; out_ready = 1'b0;
        issue(17'h1_E008);
        #1;
        checks++;
        if (out_we !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL out_blocked: got we=%b ret=%b want 0/0", out_we, retire);
        end
        tick();
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_we !== 1'b1 || retire !== 1'b1) begin
            errors++;
            $display("FAIL out_complete: got we=%b ret=%b want 1/1", out_we, retire);
        end
        tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h82 || out_we !== 1'b0) begin
            errors++;
            $display("FAIL out_done: got pc=%h we=%b want 82/0", pc, out_we);
        end
    endtask

    task automatic test_wrap_and_hold();
        clear_decoder();
        BS_in = 2'b10; jump_target = 8'hFF;
        issue(17'h0_5009); tick(); exp_cnt++;
        clear_decoder();
        issue(17'h0_0000);
        #1;
        checks++;
        if ({RW, MW, out_we, in_en, retire} !== 5'b00001) begin
            errors++;
            $display("FAIL nop_exec: got %b want 00001", {RW, MW, out_we, in_en, retire});
        end
        tick(); exp_cnt++;
        #1;
        checks++;
        if (pc !== 8'h00 || ir !== 17'h0 || retired_count !== exp_cnt) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%h ir=%h cnt=%h want 00/0/%h",
                     pc, ir, retired_count, exp_cnt);
        end
        imem_data = 17'h1_AAAA; imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (imem_req !== 1'b1 || ir !== 17'h0 || pc !== 8'h00 || retire !== 1'b0) begin
                errors++;
                $display("FAIL fetch_hold%0d: got req=%b ir=%h pc=%h want 1/0/00",
                         i, imem_req, ir, pc);
            end
        end
    endtask

    task automatic test_reset_in_iowait();
        clear_decoder();
        in_en_in = 1'b1; RW_in = 1'b1; in_valid = 1'b0;
        issue(17'h1_C00A);
        tick();
        reset = 1'b1; in_valid = 1'b1;  // would complete now without reset
        #1;
        checks++;
        if ({RW, in_en, retire} !== 3'b000) begin
            errors++;
            $display("FAIL rst_iowait_gate: got %b want 000", {RW, in_en, retire});
        end
        tick();
        reset = 1'b0;
        exp_cnt = 16'd0;
        #1;
        checks++;
        if (pc !== 8'h00 || ir !== 17'h0 || retired_count !== exp_cnt || imem_req !== 1'b1 ||
            retire !== 1'b0 || in_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_iowait_state: got pc=%h ir=%h cnt=%h req=%b ret=%b en=%b",
                     pc, ir, retired_count, imem_req, retire, in_en);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_branch();
        test_bnz_jump();
        test_io_wait();
        test_wrap_and_hold();
        test_reset_in_iowait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
